// File: rtl/gpio_bank_if.sv
// Memory-mapped bus contract between memory_controller and the GPIO bank.
// Byte address, write data, a pre-qualified write strobe and combinational read data.
interface gpio_bank_if;
  logic [31:0] gpio_addr;
  logic [31:0] gpio_wrdata;
  logic        gpio_wren;
  logic [31:0] gpio_rddata;

  modport master (
    output gpio_addr,
    output gpio_wrdata,
    output gpio_wren,
    input  gpio_rddata
  );

  modport slave (
    input  gpio_addr,
    input  gpio_wrdata,
    input  gpio_wren,
    output gpio_rddata
  );
endinterface

// File: rtl/gpio_bank.sv
// NUM_PORTS x PORT_WIDTH GPIO bank with synchronised inputs, edge interrupts and W1C status.
// Optional per-pin input debounce filter is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank #(
  parameter int          NUM_PORTS       = 2,
  parameter int          PORT_WIDTH      = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  gpio_bank_if.slave                        bus,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0]   gpio_port_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]   gpio_port_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]   gpio_port_oe,
  output logic                              irq
);

  localparam int          W            = NUM_PORTS * PORT_WIDTH;
  localparam logic [31:0] WINDOW_BYTES = 32'(NUM_PORTS * 32);

  typedef enum logic [2:0] {
    REG_OUT        = 3'd0,
    REG_DIR        = 3'd1,
    REG_IN         = 3'd2,
    REG_IRQ_EN     = 3'd3,
    REG_IRQ_STATUS = 3'd4,
    REG_EDGE_SEL   = 3'd5
  } reg_e;

  logic [PORT_WIDTH-1:0] out_q      [NUM_PORTS];
  logic [PORT_WIDTH-1:0] dir_q      [NUM_PORTS];
  logic [PORT_WIDTH-1:0] irq_en_q   [NUM_PORTS];
  logic [PORT_WIDTH-1:0] status_q   [NUM_PORTS];
  logic [PORT_WIDTH-1:0] edge_sel_q [NUM_PORTS];

  logic [PORT_WIDTH-1:0] edge_hit   [NUM_PORTS];
  logic [PORT_WIDTH-1:0] clr_mask   [NUM_PORTS];

  logic [W-1:0]          sync_q     [SYNC_STAGES];
  logic [W-1:0]          sync_in;
  logic [W-1:0]          pin_val;
  logic [W-1:0]          prev_q;

  logic [31:0]           offset;
  logic                  in_range;
  logic [2:0]            reg_sel;
  logic [PORT_WIDTH-1:0] wdata;
  logic [NUM_PORTS-1:0]  port_hit;
  logic                  unused_ok;

  // Subtracting first keeps the range test free of overflow near the top of the map.
  assign offset   = bus.gpio_addr - BASE_ADDR;
  assign in_range = (bus.gpio_addr >= BASE_ADDR) && (offset < WINDOW_BYTES);
  assign reg_sel  = offset[4:2];
  assign wdata    = bus.gpio_wrdata[PORT_WIDTH-1:0];

  assign unused_ok = ^{offset[1:0], bus.gpio_wrdata, 32'(DEBOUNCE_CYCLES)};

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_hit[p] = in_range && (offset[31:5] == 27'(p));
    end
  end

  // Input synchroniser chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every stage is reset so a reset also discards any pin history in flight.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage read last cycle's value of its neighbour.
      sync_q[0] <= gpio_port_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] db_cnt_q [W];
  logic [W-1:0]  db_q;

  // A pin's filtered value follows sync_in only after it has disagreed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q <= '0;
      for (int i = 0; i < W; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (sync_in[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CNT_LAST) begin
          db_q[i]     <= sync_in[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign pin_val = db_q;
`else
  assign pin_val = sync_in;
`endif

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      edge_hit[p] = ( edge_sel_q[p] &  pin_val[p*PORT_WIDTH +: PORT_WIDTH] & ~prev_q[p*PORT_WIDTH +: PORT_WIDTH])
                  | (~edge_sel_q[p] & ~pin_val[p*PORT_WIDTH +: PORT_WIDTH] &  prev_q[p*PORT_WIDTH +: PORT_WIDTH]);
      clr_mask[p] = (bus.gpio_wren && port_hit[p] && (reg_sel == REG_IRQ_STATUS)) ? wdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_q[p]      <= '0;
        dir_q[p]      <= '0;
        irq_en_q[p]   <= '0;
        status_q[p]   <= '0;
        edge_sel_q[p] <= '0;
      end
    end else begin
      prev_q <= pin_val;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bus.gpio_wren && port_hit[p]) begin
          case (reg_sel)
            REG_OUT:      out_q[p]      <= wdata;
            REG_DIR:      dir_q[p]      <= wdata;
            REG_IRQ_EN:   irq_en_q[p]   <= wdata;
            REG_EDGE_SEL: edge_sel_q[p] <= wdata;
            default:      ;
          endcase
        end
        // A new edge in the same cycle as a clear keeps the bit set.
        status_q[p] <= (status_q[p] & ~clr_mask[p]) | (edge_hit[p] & irq_en_q[p]);
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    bus.gpio_rddata = '0;
    irq             = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      irq = irq | (|(status_q[p] & irq_en_q[p]));
      if (port_hit[p]) begin
        case (reg_sel)
          REG_OUT:        bus.gpio_rddata = 32'(out_q[p]);
          REG_DIR:        bus.gpio_rddata = 32'(dir_q[p]);
          REG_IN:         bus.gpio_rddata = 32'(pin_val[p*PORT_WIDTH +: PORT_WIDTH]);
          REG_IRQ_EN:     bus.gpio_rddata = 32'(irq_en_q[p]);
          REG_IRQ_STATUS: bus.gpio_rddata = 32'(status_q[p]);
          REG_EDGE_SEL:   bus.gpio_rddata = 32'(edge_sel_q[p]);
          default:        bus.gpio_rddata = '0;
        endcase
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pins
    assign gpio_port_out[p*PORT_WIDTH +: PORT_WIDTH] = out_q[p];
    assign gpio_port_oe[p*PORT_WIDTH +: PORT_WIDTH]  = dir_q[p];
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed register/interrupt cases plus randomized
// traffic compared against a delayed-pin behavioural model.
`timescale 1ns/1ps
module tb_gpio_bank;
  localparam int          NP   = 2;
  localparam int          PW   = 8;
  localparam int          SS   = 2;
  localparam int          DB   = 4;
  localparam int          W    = NP * PW;
  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT  = SS + DB;
  localparam int HOLD = DB + 1;
`else
  localparam int LAT  = SS;
  localparam int HOLD = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pins;
  logic [W-1:0] port_out;
  logic [W-1:0] port_oe;
  logic         irq;

  gpio_bank_if bus ();

  gpio_bank #(
    .NUM_PORTS(NP), .PORT_WIDTH(PW), .BASE_ADDR(BASE),
    .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .gpio_port_in (pins),
    .gpio_port_out(port_out),
    .gpio_port_oe (port_oe),
    .irq          (irq)
  );

  always #50 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register contents plus a history of sampled pin vectors.
  logic [PW-1:0] m_out [NP];
  logic [PW-1:0] m_dir [NP];
  logic [PW-1:0] m_en  [NP];
  logic [PW-1:0] m_st  [NP];
  logic [PW-1:0] m_es  [NP];
  logic [W-1:0]  hist  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_out[p] = '0; m_dir[p] = '0; m_en[p] = '0; m_st[p] = '0; m_es[p] = '0;
    end
    hist.delete();
    for (int i = 0; i <= LAT; i++) hist.push_back('0);
  endtask

  // IN as seen by software: the pin vector sampled LAT-1 edges ago.
  function automatic logic [PW-1:0] model_in(int p);
    logic [W-1:0] v;
    v = hist[LAT-1];
    return v[p*PW +: PW];
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] addr);
    logic [31:0] off;
    int p, r;
    if (addr < BASE) return 32'h0;
    off = addr - BASE;
    if (off >= 32'(NP * 32)) return 32'h0;
    p = int'(off / 32);
    r = int'(off % 32) / 4;
    case (r)
      0:       return 32'(m_out[p]);
      1:       return 32'(m_dir[p]);
      2:       return 32'(model_in(p));
      3:       return 32'(m_en[p]);
      4:       return 32'(m_st[p]);
      5:       return 32'(m_es[p]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [W-1:0] model_vec(int which);
    logic [W-1:0] v;
    for (int p = 0; p < NP; p++) v[p*PW +: PW] = (which == 0) ? m_out[p] : m_dir[p];
    return v;
  endfunction

  function automatic logic model_irq();
    logic r;
    r = 1'b0;
    for (int p = 0; p < NP; p++) r = r | (|(m_st[p] & m_en[p]));
    return r;
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [W-1:0]  cur, prv;
    logic [PW-1:0] c, v, wd;
    logic [PW-1:0] set [NP];
    logic [PW-1:0] clr [NP];
    logic [31:0]   off;
    int p, r;
    cur = hist[LAT-1];
    prv = hist[LAT];
    for (int q = 0; q < NP; q++) begin
      c = cur[q*PW +: PW];
      v = prv[q*PW +: PW];
      set[q] = ((m_es[q] & c & ~v) | (~m_es[q] & ~c & v)) & m_en[q];
      clr[q] = '0;
    end
    off = bus.gpio_addr - BASE;
    if (bus.gpio_wren && bus.gpio_addr >= BASE && off < 32'(NP * 32)) begin
      p  = int'(off / 32);
      r  = int'(off % 32) / 4;
      wd = bus.gpio_wrdata[PW-1:0];
      case (r)
        0:       m_out[p] = wd;
        1:       m_dir[p] = wd;
        3:       m_en[p]  = wd;
        4:       clr[p]   = wd;
        5:       m_es[p]  = wd;
        default: ;
      endcase
    end
    for (int q = 0; q < NP; q++) m_st[q] = (m_st[q] & ~clr[q]) | set[q];
    hist.push_front(pins);
    void'(hist.pop_back());
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.gpio_addr   = addr;
    bus.gpio_wrdata = data;
    bus.gpio_wren   = 1'b1;
    step();
    bus.gpio_wren   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr);
    bus.gpio_addr = addr;
    #1;
    check(tag, bus.gpio_rddata, model_read(addr));
  endtask

  task automatic check_pins(input string tag);
    check({tag, "_out"}, 32'(port_out), 32'(model_vec(0)));
    check({tag, "_oe"},  32'(port_oe),  32'(model_vec(1)));
    check({tag, "_irq"}, 32'(irq),      32'(model_irq()));
  endtask

  task automatic check_all_regs(input string tag);
    for (int p = 0; p < NP; p++)
      for (int r = 0; r < 8; r++)
        read_check($sformatf("%s_p%0d_r%0d", tag, p, r), BASE + 32'(p * 32 + r * 4));
    read_check({tag, "_past_end"}, BASE + 32'(NP * 32));
    read_check({tag, "_below"},    BASE - 32'd4);
    check_pins(tag);
  endtask

  task automatic rand_cycle(input int i);
    logic [31:0] addr;
    if (i % HOLD == 0) pins = W'($urandom);
    if ($urandom_range(0, 15) == 0) addr = BASE - 32'($urandom_range(1, 64));
    else addr = BASE + 32'($urandom_range(0, NP) * 32 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
    bus.gpio_addr   = addr;
    bus.gpio_wrdata = $urandom;
    bus.gpio_wren   = ($urandom_range(0, 1) == 1);
    step();
    bus.gpio_wren   = 1'b0;
    check_pins("rand");
    addr = BASE + 32'($urandom_range(0, NP) * 32 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
    read_check("rand_rd", addr);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b0;
    pins            = '0;
    bus.gpio_addr   = '0;
    bus.gpio_wrdata = '0;
    bus.gpio_wren   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state.
    check("rst_out", 32'(port_out), 32'h0);
    check("rst_oe",  32'(port_oe),  32'h0);
    check("rst_irq", 32'(irq),      32'h0);
    check_all_regs("rst");

    // Port 1 OUT/DIR; port 0 bits untouched.
    bus_write(BASE + 32'h20, 32'h0000_00A5);
    bus_write(BASE + 32'h24, 32'hFFFF_FFFF);
    check("p1_out", 32'(port_out), 32'h0000_A500);
    check("p1_oe",  32'(port_oe),  32'h0000_FF00);
    check_all_regs("p1");

    // Rising edge on pin 0 with interrupt enabled.
    bus_write(BASE + 32'h0C, 32'h1);
    bus_write(BASE + 32'h14, 32'h1);
    pins[0] = 1'b1;
    bus.gpio_addr = BASE + 32'h08;
    for (int c = 1; c <= LAT + 1; c++) begin
      step();
      check($sformatf("edge_in_%0d", c),  bus.gpio_rddata, (c >= LAT) ? 32'h1 : 32'h0);
      check($sformatf("edge_irq_%0d", c), 32'(irq), (c >= LAT + 1) ? 32'h1 : 32'h0);
    end
    read_check("edge_status", BASE + 32'h10);
    check("edge_status_val", bus.gpio_rddata, 32'h1);
    bus_write(BASE + 32'h10, 32'h1);
    read_check("w1c_status", BASE + 32'h10);
    check("w1c_status_val", bus.gpio_rddata, 32'h0);
    check("w1c_irq", 32'(irq), 32'h0);

    // Edge detection and W1C on the same bit in the same cycle: set wins.
    pins[0] = 1'b0;
    repeat (LAT + 2) step();
    bus_write(BASE + 32'h10, 32'hFF);
    read_check("pre_race_status", BASE + 32'h10);
    pins[0] = 1'b1;
    step();
    repeat (LAT - 1) step();
    bus_write(BASE + 32'h10, 32'h1);
    read_check("race_status", BASE + 32'h10);
    check("race_status_val", bus.gpio_rddata, 32'h1);
    check("race_irq", 32'(irq), 32'h1);

    // Disabling the enable masks irq but keeps status.
    bus_write(BASE + 32'h0C, 32'h0);
    check("mask_irq", 32'(irq), 32'h0);
    read_check("mask_status", BASE + 32'h10);
    check("mask_status_val", bus.gpio_rddata, 32'h1);

    // Unmapped writes are ignored and read back as zero.
    bus_write(BASE + 32'h40, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h18, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h1C, 32'hFFFF_FFFF);
    bus.gpio_addr = BASE + 32'h40;
    #1;
    check("unmapped_40", bus.gpio_rddata, 32'h0);
    bus.gpio_addr = BASE + 32'h18;
    #1;
    check("unmapped_18", bus.gpio_rddata, 32'h0);
    check_all_regs("unmapped");

    // Randomized traffic.
    for (int i = 0; i < 300; i++) rand_cycle(i);
    check_all_regs("rand_end");

    // Asynchronous reset in the middle of activity.
    rst = 1'b0;
    #1;
    check("mid_rst_out", 32'(port_out), 32'h0);
    check("mid_rst_oe",  32'(port_oe),  32'h0);
    check("mid_rst_irq", 32'(irq),      32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_all_regs("mid_rst");
    for (int i = 0; i < 100; i++) rand_cycle(i);
    check_all_regs("post_rst");

`ifdef GPIO_DEBOUNCE_EN
    // Short glitch on pin 3 is filtered; a long pulse passes after SS + DB edges.
    pins = '0;
    bus_write(BASE + 32'h0C, 32'h08);
    bus_write(BASE + 32'h14, 32'h08);
    repeat (LAT + 2) step();
    bus_write(BASE + 32'h10, 32'hFF);
    bus.gpio_addr = BASE + 32'h08;
    pins[3] = 1'b1;
    for (int c = 1; c <= LAT + 6; c++) begin
      step();
      if (c == 3) pins[3] = 1'b0;
      check($sformatf("glitch_in_%0d", c), bus.gpio_rddata, 32'h0);
    end
    bus.gpio_addr = BASE + 32'h10;
    #1;
    check("glitch_status", bus.gpio_rddata, 32'h0);
    bus.gpio_addr = BASE + 32'h08;
    pins[3] = 1'b1;
    for (int c = 1; c <= LAT + 1; c++) begin
      step();
      if (c == 6) pins[3] = 1'b0;
      check($sformatf("pulse_in_%0d", c), bus.gpio_rddata, (c >= LAT) ? 32'h08 : 32'h0);
    end
    bus.gpio_addr = BASE + 32'h10;
    #1;
    check("pulse_status", bus.gpio_rddata, 32'h08);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
